reaction_display: RTL and testbench

- Downstream consumer of the reaction-timer core's 14-bit `reaction` result (milliseconds, 0..9999).
- On a `load` pulse it converts the binary value to 4 BCD digits with a sequential double-dabble (one shift per cycle).
- It then drives a time-multiplexed 4-digit active-low 7-segment display with leading-zero blanking.
- The displayed value stays stable until the next conversion commits.

---
 rtl/reaction_pkg.sv | 39 +++
 rtl/bin2bcd_seq.sv | 148 ++++++++++++++
 rtl/reaction_display.sv | 96 +++++++++
 tb/tb_reaction_display.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time display path.
// Contents: result/BCD widths, converter FSM states, 7-segment blank code
// and the BCD-to-segment decode function (active-low, {g,f,e,d,c,b,a}).
package reaction_pkg;

  localparam int unsigned REACTION_W = 14;
  localparam int unsigned DIGITS     = 4;
  localparam int unsigned BCD_W      = 4 * DIGITS;
  localparam int unsigned ITER_W     = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Active-low gfedcba pattern for one BCD nibble; non-BCD codes are blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4 BCD digits, one
// shift per clock, with a one-deep pending request (latest load wins).
// Ports:
//   clk, areset (sync, active-low)
//   load/value  : request to convert value (saturated to MAX_VAL)
//   busy        : conversion in progress or pending
//   done        : one-cycle pulse when digits commit
//   ovf         : last committed value was saturated
//   digits      : committed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq
  import reaction_pkg::*;
#(
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  load,
  input  logic [REACTION_W-1:0] value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [BCD_W-1:0]      digits
);

  localparam logic [REACTION_W-1:0] MAX_V   = REACTION_W'(MAX_VAL);
  localparam logic [ITER_W-1:0]     LAST_IT = ITER_W'(REACTION_W - 1);

  conv_state_e           state_q, state_d;
  logic [REACTION_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  ovf_work_q, ovf_work_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [REACTION_W-1:0] pend_val_q, pend_val_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [BCD_W-1:0]      digits_q, digits_d;

  logic                  start;
  logic [REACTION_W-1:0] start_val;
  logic [BCD_W-1:0]      bcd_adj;

  // Add 3 to every nibble >= 5 so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_work_d = ovf_work_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    start      = 1'b0;
    start_val  = value;
    bcd_adj    = dabble_adjust(bcd_q);

    case (state_q)
      ST_IDLE: begin
        if (load) start = 1'b1;
      end
      ST_SHIFT: begin
        if (load) begin
          pend_vld_d = 1'b1;
          pend_val_d = value;
        end
        bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[REACTION_W-1]};
        bin_d  = {bin_q[REACTION_W-2:0], 1'b0};
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == LAST_IT) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        digits_d   = bcd_q;
        ovf_d      = ovf_work_q;
        done_d     = 1'b1;
        pend_vld_d = 1'b0;
        // A load on this very edge is newer than anything pending.
        if (load) begin
          start = 1'b1;
        end else if (pend_vld_q) begin
          start     = 1'b1;
          start_val = pend_val_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Common setup for a new conversion.
    if (start) begin
      state_d    = ST_SHIFT;
      ovf_work_d = (start_val > MAX_V);
      bin_d      = (start_val > MAX_V) ? MAX_V : start_val;
      bcd_d      = '0;
      iter_d     = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_work_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_work_q <= ovf_work_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digits = digits_q;

endmodule

// File: rtl/reaction_display.sv
// Reaction-time display: converts a binary ms value to BCD on load and
// drives a multiplexed 4-digit active-low 7-segment display with
// leading-zero blanking.
// Ports:
//   clk, areset (sync, active-low)
//   load/value  : capture a new reaction time
//   busy/done/ovf : converter status
//   seg         : {g,f,e,d,c,b,a}, active-low
//   an          : digit enables, active-low, an[0] = least-significant digit
module reaction_display
  import reaction_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned MAX_VAL  = 9999
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  load,
  input  logic [REACTION_W-1:0] value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [SEG_W-1:0]      seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [BCD_W-1:0]  digits;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS-1:0] lz;
  logic              upper_zero;
  logic [3:0]        nib;

  bin2bcd_seq #(
    .MAX_VAL (MAX_VAL)
  ) u_conv (
    .clk    (clk),
    .areset (areset),
    .load   (load),
    .value  (value),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .digits (digits)
  );

  // lz[k]: digits k..DIGITS-1 are all zero.
  always_comb begin
    lz         = '0;
    upper_zero = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (digits[4*k +: 4] == 4'd0);
      lz[k]      = upper_zero;
    end
  end

  // Scan advance and registered segment/anode selection for the current slot.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    nib  = digits[{idx_q, 2'b00} +: 4];
    an_d = ~(DIGITS'(1) << idx_q);
    if ((idx_q != '0) && lz[idx_q]) seg_d = SEG_BLANK;
    else                            seg_d = seg_decode(nib);
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_reaction_display.sv
module tb_reaction_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned MAX_VAL  = 9999;
  localparam int          LAT      = 15;

  logic        clk = 1'b0;
  logic        areset;
  logic        load;
  logic [13:0] value;
  logic        busy, done, ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: edges since reset release, and value currently on display.
  int scan_t   = 0;
  int disp_val = 0;
  logic [6:0] seg_tab [10];

  reaction_display #(
    .SCAN_DIV (SCAN_DIV),
    .MAX_VAL  (MAX_VAL)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .load   (load),
    .value  (value),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .seg    (seg),
    .an     (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) scan_t <= (areset === 1'b1) ? scan_t + 1 : 0;

  function automatic int slot_idx();
    return ((scan_t - 1) / int'(SCAN_DIV)) % 4;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    if (scan_t == 0) return 4'hF;
    one = 4'b0001;
    return ~(one << slot_idx());
  endfunction

  function automatic logic [6:0] exp_seg(input int v);
    int sat, idx, p;
    if (scan_t == 0) return 7'h7F;
    sat = (v > int'(MAX_VAL)) ? int'(MAX_VAL) : v;
    idx = slot_idx();
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && sat < p) return 7'h7F;
    return seg_tab[(sat / p) % 10];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    areset = 1'b0; load = 1'b0; value = '0;
    repeat (2) step();
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      n_err++;
      $display("FAIL reset_disp an=%b seg=%b want an=1111 seg=1111111", an, seg);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags busy=%b done=%b ovf=%b want 0 0 0", busy, done, ovf);
    end
    areset   = 1'b1;
    disp_val = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      n_cmp++;
      if (an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL reset_scan j=%0d an=%b seg=%b want an=%b seg=%b",
                 j, an, seg, exp_an(), exp_seg(disp_val));
      end
    end
  endtask

  // One isolated conversion followed by a full scan of the result.
  task automatic test_convert(input int v, input string tag);
    load = 1'b1; value = 14'(v);
    for (int k = 0; k <= LAT; k++) begin
      step();
      load = 1'b0;
      n_cmp++;
      if (busy !== (k < LAT) || done !== (k == LAT)) begin
        n_err++;
        $display("FAIL %s_ctl v=%0d k=%0d busy=%b done=%b want busy=%b done=%b",
                 tag, v, k, busy, done, k < LAT, k == LAT);
      end
      n_cmp++;
      if (an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL %s_disp v=%0d k=%0d an=%b seg=%b want an=%b seg=%b",
                 tag, v, k, an, seg, exp_an(), exp_seg(disp_val));
      end
      if (k == LAT) begin
        n_cmp++;
        if (ovf !== (v > int'(MAX_VAL))) begin
          n_err++;
          $display("FAIL %s_ovf v=%0d ovf=%b want %b", tag, v, ovf, v > int'(MAX_VAL));
        end
        disp_val = v;
      end
    end
    for (int j = 0; j < 4 * int'(SCAN_DIV) + 1; j++) begin
      step();
      n_cmp++;
      if (an !== exp_an() || seg !== exp_seg(disp_val) || busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL %s_scan v=%0d j=%0d an=%b seg=%b busy=%b done=%b want an=%b seg=%b busy=0 done=0",
                 tag, v, j, an, seg, busy, done, exp_an(), exp_seg(disp_val));
      end
    end
  endtask

  task automatic test_load_347();
    test_convert(347, "v347");
  endtask

  task automatic test_overflow();
    test_convert(12000, "ovf_hi");
    test_convert(42, "ovf_clr");
  endtask

  // Loads at E0, E3, E8: the E8 value replaces the E3 one in pending.
  task automatic test_pending();
    load = 1'b1; value = 14'd5;
    for (int k = 0; k <= 2 * LAT + 1; k++) begin
      step();
      load = 1'b0;
      if (k + 1 == 3) begin load = 1'b1; value = 14'd1230; end
      if (k + 1 == 8) begin load = 1'b1; value = 14'd1; end
      n_cmp++;
      if (busy !== (k < 2 * LAT) || done !== (k == LAT || k == 2 * LAT)) begin
        n_err++;
        $display("FAIL pend_ctl k=%0d busy=%b done=%b want busy=%b done=%b",
                 k, busy, done, k < 2 * LAT, k == LAT || k == 2 * LAT);
      end
      n_cmp++;
      if (an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL pend_disp k=%0d an=%b seg=%b want an=%b seg=%b",
                 k, an, seg, exp_an(), exp_seg(disp_val));
      end
      if (k == LAT) disp_val = 5;
      if (k == 2 * LAT) disp_val = 1;
    end
  endtask

  // Second load lands exactly on the commit edge of the first.
  task automatic test_back_to_back();
    int a, b;
    for (int r = 0; r < 3; r++) begin
      a = int'($urandom_range(0, 16383));
      b = int'($urandom_range(0, 12000));
      load = 1'b1; value = 14'(a);
      for (int k = 0; k <= 2 * LAT + 1; k++) begin
        step();
        load = 1'b0;
        if (k + 1 == LAT) begin load = 1'b1; value = 14'(b); end
        n_cmp++;
        if (busy !== (k < 2 * LAT) || done !== (k == LAT || k == 2 * LAT)) begin
          n_err++;
          $display("FAIL b2b_ctl a=%0d b=%0d k=%0d busy=%b done=%b", a, b, k, busy, done);
        end
        n_cmp++;
        if (an !== exp_an() || seg !== exp_seg(disp_val)) begin
          n_err++;
          $display("FAIL b2b_disp a=%0d b=%0d k=%0d an=%b seg=%b want an=%b seg=%b",
                   a, b, k, an, seg, exp_an(), exp_seg(disp_val));
        end
        if (k == LAT || k == 2 * LAT) begin
          n_cmp++;
          if (ovf !== ((k == LAT ? a : b) > int'(MAX_VAL))) begin
            n_err++;
            $display("FAIL b2b_ovf k=%0d ovf=%b want %b", k, ovf, (k == LAT ? a : b) > int'(MAX_VAL));
          end
          disp_val = (k == LAT) ? a : b;
        end
      end
    end
  endtask

  // Reset at E7 with a request pending: nothing may ever commit.
  task automatic test_reset_mid();
    load = 1'b1; value = 14'd9876;
    for (int k = 0; k < 7; k++) begin
      step();
      load = 1'b0;
      if (k + 1 == 3) begin load = 1'b1; value = 14'd321; end
      if (k + 1 == 7) areset = 1'b0;
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || an !== 4'hF || seg !== 7'h7F) begin
      n_err++;
      $display("FAIL rstmid_now busy=%b done=%b ovf=%b an=%b seg=%b want 0 0 0 1111 1111111",
               busy, done, ovf, an, seg);
    end
    areset   = 1'b1;
    disp_val = 0;
    for (int j = 0; j < 40; j++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || an !== exp_an() || seg !== exp_seg(disp_val)) begin
        n_err++;
        $display("FAIL rstmid_after j=%0d busy=%b done=%b an=%b seg=%b want busy=0 done=0 an=%b seg=%b",
                 j, busy, done, an, seg, exp_an(), exp_seg(disp_val));
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int r = 0; r < 8; r++) begin
      case (r % 4)
        0:       v = int'($urandom_range(0, 9));
        1:       v = int'($urandom_range(10, 999));
        2:       v = int'($urandom_range(1000, 9999));
        default: v = int'($urandom_range(0, 16383));
      endcase
      test_convert(v, "rand");
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    areset = 1'b0;
    load   = 1'b0;
    value  = '0;
    test_reset();
    test_load_347();
    test_overflow();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
